// File: rtl/sdram_burst_traffic_gen.sv
// -----------------------------------------------------------------------------
// sdram_burst_traffic_gen
//
// Write-then-read-back traffic generator and checker for the SDRAM
// controller's application burst port. A pass writes NUM_BURSTS bursts of
// BURST_LEN beats starting at START_ADDR, then reads the same region back and
// compares every returned beat against regenerated pattern data. Mismatches,
// protocol violations and timeouts are counted in a saturating error counter.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      one-cycle pulse, starts a pass when idle
//   wr_burst_req/len/addr/data write burst request side (data is combinational)
//   wr_burst_data_req          controller consumes wr_burst_data this cycle
//   wr_burst_finish            write burst complete pulse
//   rd_burst_req/len/addr      read burst request side
//   rd_burst_data/_valid       read beat data from the controller
//   rd_burst_finish            read burst complete pulse
//   busy                       pass in progress
//   done                       sticky, pass completed (or aborted on timeout)
//   error, err_count           sticky error flag and saturating error count
//   o_led_receive_done         done & ~error, registered
// -----------------------------------------------------------------------------
module sdram_burst_traffic_gen #(
    parameter int          APP_ADDR_WIDTH  = 24,
    parameter int          APP_BURST_WIDTH = 10,
    parameter int          SDR_DQ_WIDTH    = 16,
    parameter int          BURST_LEN       = 4,
    parameter int          NUM_BURSTS      = 16,
    parameter int unsigned START_ADDR      = 32'd0,
    parameter int          PATTERN         = 0,
    parameter int          LOOP            = 0,
    parameter int          TIMEOUT         = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       wr_burst_req,
    output logic [APP_BURST_WIDTH-1:0] wr_burst_len,
    output logic [APP_ADDR_WIDTH-1:0]  wr_burst_addr,
    output logic [SDR_DQ_WIDTH-1:0]    wr_burst_data,
    input  logic                       wr_burst_data_req,
    input  logic                       wr_burst_finish,
    output logic                       rd_burst_req,
    output logic [APP_BURST_WIDTH-1:0] rd_burst_len,
    output logic [APP_ADDR_WIDTH-1:0]  rd_burst_addr,
    input  logic [SDR_DQ_WIDTH-1:0]    rd_burst_data,
    input  logic                       rd_burst_data_valid,
    input  logic                       rd_burst_finish,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [15:0]                err_count,
    output logic                       o_led_receive_done
);

    // Beat counter is one bit wider than the length field so it can hold BURST_LEN itself.
    localparam int BEAT_W  = APP_BURST_WIDTH + 1;
    localparam int BURST_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int TMR_W   = $clog2(TIMEOUT + 1);

    localparam logic [BEAT_W-1:0]  BEAT_LAST  = BEAT_W'(BURST_LEN);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(NUM_BURSTS - 1);
    localparam logic [TMR_W-1:0]   TMR_LIMIT  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_WAIT = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_WAIT = 3'd4,
        S_END     = 3'd5
    } state_t;

    state_t                     state_r, state_n;
    logic [BURST_W-1:0]         burst_r, burst_n;
    logic [BEAT_W-1:0]          beat_r, beat_n;
    logic [SDR_DQ_WIDTH-1:0]    seed_r, seed_n;
    logic [TMR_W-1:0]           tmr_r, tmr_n;
    logic                       wr_req_r, wr_req_n;
    logic                       rd_req_r, rd_req_n;
    logic [APP_ADDR_WIDTH-1:0]  addr_r, addr_n;
    logic                       busy_r;
    logic                       done_r, done_n;
    logic                       error_r, error_n;
    logic                       led_r, led_n;
    logic [15:0]                err_cnt_r, err_cnt_n;
    logic [15:0]                err_base_s;
    logic [16:0]                err_sum_s;

    // Start address of burst b, wrapping silently at the top of the address space.
    function automatic logic [APP_ADDR_WIDTH-1:0] burst_addr(input logic [BURST_W-1:0] b);
        logic [63:0] s;
        s = 64'(START_ADDR) + 64'(b) * 64'(BURST_LEN);
        return APP_ADDR_WIDTH'(s);
    endfunction

    // Pattern word for (seed, burst, beat); shared by write generation and read check.
    function automatic logic [SDR_DQ_WIDTH-1:0] gen_data(
        input logic [SDR_DQ_WIDTH-1:0] seed,
        input logic [BURST_W-1:0]      b,
        input logic [BEAT_W-1:0]       beat
    );
        logic [31:0]               k;
        logic [31:0]               sh;
        logic [APP_ADDR_WIDTH-1:0] a;
        logic [SDR_DQ_WIDTH-1:0]   one_v;
        logic [SDR_DQ_WIDTH-1:0]   d;
        k     = 32'(b) * 32'(BURST_LEN) + 32'(beat);
        sh    = (k + 32'(seed)) % 32'(SDR_DQ_WIDTH);
        a     = burst_addr(b) + APP_ADDR_WIDTH'(beat);
        one_v = {{(SDR_DQ_WIDTH-1){1'b0}}, 1'b1};
        case (PATTERN)
            32'sd0:  d = seed + SDR_DQ_WIDTH'(k);
            32'sd1:  d = one_v << sh;
            32'sd2:  d = SDR_DQ_WIDTH'(a) ^ seed;
            default: d = {SDR_DQ_WIDTH{1'b0}};
        endcase
        return d;
    endfunction

    logic                    in_wr_wait_s, in_rd_wait_s;
    logic                    wr_beat_ok_s, rd_beat_ok_s;
    logic                    wr_ovf_s, rd_ovf_s;
    logic [BEAT_W-1:0]       wr_beats_s, rd_beats_s;
    logic                    wr_short_s, rd_short_s;
    logic                    rd_miss_s;
    logic                    stray_wdat_s, stray_rdat_s, stray_wfin_s, stray_rfin_s;
    logic                    tmo_s;
    logic [2:0]              err_inc_s;
    logic [SDR_DQ_WIDTH-1:0] exp_data_s;

    assign in_wr_wait_s = (state_r == S_WR_WAIT);
    assign in_rd_wait_s = (state_r == S_RD_WAIT);
    assign exp_data_s   = gen_data(seed_r, burst_r, beat_r);

    assign wr_beat_ok_s = in_wr_wait_s && wr_burst_data_req   && (beat_r < BEAT_LAST);
    assign rd_beat_ok_s = in_rd_wait_s && rd_burst_data_valid && (beat_r < BEAT_LAST);
    assign wr_ovf_s     = in_wr_wait_s && wr_burst_data_req   && (beat_r == BEAT_LAST);
    assign rd_ovf_s     = in_rd_wait_s && rd_burst_data_valid && (beat_r == BEAT_LAST);

    // A beat arriving together with finish counts towards the length check.
    assign wr_beats_s   = beat_r + BEAT_W'(wr_beat_ok_s);
    assign rd_beats_s   = beat_r + BEAT_W'(rd_beat_ok_s);
    assign wr_short_s   = in_wr_wait_s && wr_burst_finish && (wr_beats_s < BEAT_LAST);
    assign rd_short_s   = in_rd_wait_s && rd_burst_finish && (rd_beats_s < BEAT_LAST);

    assign rd_miss_s    = rd_beat_ok_s && (rd_burst_data != exp_data_s);

    assign stray_wdat_s = wr_burst_data_req   && !in_wr_wait_s;
    assign stray_rdat_s = rd_burst_data_valid && !in_rd_wait_s;
    assign stray_wfin_s = wr_burst_finish && !wr_req_r;
    assign stray_rfin_s = rd_burst_finish && !rd_req_r;

    assign tmo_s = (tmr_r == TMR_LIMIT) &&
                   ((in_wr_wait_s && !wr_burst_finish) || (in_rd_wait_s && !rd_burst_finish));

    // Every independent error source in a cycle adds one to the count.
    assign err_inc_s = 3'(wr_ovf_s)     + 3'(rd_ovf_s)     + 3'(wr_short_s)   + 3'(rd_short_s) +
                       3'(rd_miss_s)    + 3'(stray_wdat_s) + 3'(stray_rdat_s) +
                       3'(stray_wfin_s) + 3'(stray_rfin_s) + 3'(tmo_s);

    // Next-state and next-register computation for the pass sequencer.
    always_comb begin
        state_n    = state_r;
        burst_n    = burst_r;
        beat_n     = beat_r;
        seed_n     = seed_r;
        tmr_n      = tmr_r;
        wr_req_n   = wr_req_r;
        rd_req_n   = rd_req_r;
        addr_n     = addr_r;
        done_n     = done_r;
        error_n    = error_r;
        err_base_s = err_cnt_r;
        err_sum_s  = 17'd0;
        err_cnt_n  = err_cnt_r;
        led_n      = led_r;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    burst_n    = {BURST_W{1'b0}};
                    done_n     = 1'b0;
                    error_n    = 1'b0;
                    err_base_s = 16'd0;
                    state_n    = S_WR_REQ;
                end else begin
                    state_n    = S_IDLE;
                end
            end
            S_WR_REQ: begin
                addr_n   = burst_addr(burst_r);
                wr_req_n = 1'b1;
                beat_n   = {BEAT_W{1'b0}};
                tmr_n    = {TMR_W{1'b0}};
                state_n  = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                tmr_n  = tmr_r + TMR_W'(1);
                beat_n = wr_beats_s;
                if (wr_burst_finish) begin
                    wr_req_n = 1'b0;
                    if (burst_r == BURST_LAST) begin
                        burst_n = {BURST_W{1'b0}};
                        state_n = S_RD_REQ;
                    end else begin
                        burst_n = burst_r + BURST_W'(1);
                        state_n = S_WR_REQ;
                    end
                end else if (tmo_s) begin
                    wr_req_n = 1'b0;
                    done_n   = 1'b1;
                    state_n  = S_IDLE;
                end else begin
                    state_n  = S_WR_WAIT;
                end
            end
            S_RD_REQ: begin
                addr_n   = burst_addr(burst_r);
                rd_req_n = 1'b1;
                beat_n   = {BEAT_W{1'b0}};
                tmr_n    = {TMR_W{1'b0}};
                state_n  = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                tmr_n  = tmr_r + TMR_W'(1);
                beat_n = rd_beats_s;
                if (rd_burst_finish) begin
                    rd_req_n = 1'b0;
                    if (burst_r == BURST_LAST) begin
                        burst_n = {BURST_W{1'b0}};
                        state_n = S_END;
                    end else begin
                        burst_n = burst_r + BURST_W'(1);
                        state_n = S_RD_REQ;
                    end
                end else if (tmo_s) begin
                    rd_req_n = 1'b0;
                    done_n   = 1'b1;
                    state_n  = S_IDLE;
                end else begin
                    state_n  = S_RD_WAIT;
                end
            end
            S_END: begin
                if (LOOP != 0) begin
                    seed_n  = seed_r + SDR_DQ_WIDTH'(1);
                    burst_n = {BURST_W{1'b0}};
                    state_n = S_WR_REQ;
                end else begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end
            end
            default: begin
                wr_req_n = 1'b0;
                rd_req_n = 1'b0;
                state_n  = S_IDLE;
            end
        endcase

        error_n   = error_n | (err_inc_s != 3'd0);
        err_sum_s = {1'b0, err_base_s} + 17'(err_inc_s);
        err_cnt_n = err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
        led_n     = done_n & ~error_n;
    end

    // State and datapath registers; reset drops both requests immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            burst_r   <= {BURST_W{1'b0}};
            beat_r    <= {BEAT_W{1'b0}};
            seed_r    <= {SDR_DQ_WIDTH{1'b0}};
            tmr_r     <= {TMR_W{1'b0}};
            wr_req_r  <= 1'b0;
            rd_req_r  <= 1'b0;
            addr_r    <= {APP_ADDR_WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            led_r     <= 1'b0;
            err_cnt_r <= 16'd0;
        end else begin
            state_r   <= state_n;
            burst_r   <= burst_n;
            beat_r    <= beat_n;
            seed_r    <= seed_n;
            tmr_r     <= tmr_n;
            wr_req_r  <= wr_req_n;
            rd_req_r  <= rd_req_n;
            addr_r    <= addr_n;
            busy_r    <= (state_n != S_IDLE);
            done_r    <= done_n;
            error_r   <= error_n;
            led_r     <= led_n;
            err_cnt_r <= err_cnt_n;
        end
    end

    assign wr_burst_req       = wr_req_r;
    assign wr_burst_len       = APP_BURST_WIDTH'(BURST_LEN);
    assign wr_burst_addr      = addr_r;
    assign wr_burst_data      = exp_data_s;
    assign rd_burst_req       = rd_req_r;
    assign rd_burst_len       = APP_BURST_WIDTH'(BURST_LEN);
    assign rd_burst_addr      = addr_r;
    assign busy               = busy_r;
    assign done               = done_r;
    assign error              = error_r;
    assign err_count          = err_cnt_r;
    assign o_led_receive_done = led_r;

endmodule

// File: tb/tb_sdram_burst_traffic_gen.sv
// -----------------------------------------------------------------------------
// Bench for sdram_burst_traffic_gen. Two instances: 'a' (incrementing pattern,
// single pass, start 0) and 'b' (walking-one, loop mode, start near the top of
// the address space). One controller model serves whichever instance 'sel'
// picks. Expected write addresses and data are pushed to queues from a bench
// model before each pass and popped as the controller model consumes beats;
// read data is returned from a memory filled by the write phase.
// -----------------------------------------------------------------------------
module tb_sdram_burst_traffic_gen;

    localparam int          AW  = 24;
    localparam int          LW  = 10;
    localparam int          DW  = 16;
    localparam int          BL  = 4;
    localparam int          NB  = 2;
    localparam int          TO  = 64;
    localparam int unsigned TOP = 32'h00FF_FFFC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          sel, start, wr_dreq, wr_fin, rd_valid, rd_fin;
    logic [DW-1:0] rd_data;

    logic          a_wr_req, a_rd_req, a_busy, a_done, a_error, a_led;
    logic [LW-1:0] a_wr_len, a_rd_len;
    logic [AW-1:0] a_wr_addr, a_rd_addr;
    logic [DW-1:0] a_wr_data;
    logic [15:0]   a_err;
    logic          b_wr_req, b_rd_req, b_busy, b_done, b_error, b_led;
    logic [LW-1:0] b_wr_len, b_rd_len;
    logic [AW-1:0] b_wr_addr, b_rd_addr;
    logic [DW-1:0] b_wr_data;
    logic [15:0]   b_err;

    logic          a_start, a_dreq, a_wfin, a_rvalid, a_rfin;
    logic          b_start, b_dreq, b_wfin, b_rvalid, b_rfin;
    assign a_start  = start & ~sel;    assign b_start  = start & sel;
    assign a_dreq   = wr_dreq & ~sel;  assign b_dreq   = wr_dreq & sel;
    assign a_wfin   = wr_fin & ~sel;   assign b_wfin   = wr_fin & sel;
    assign a_rvalid = rd_valid & ~sel; assign b_rvalid = rd_valid & sel;
    assign a_rfin   = rd_fin & ~sel;   assign b_rfin   = rd_fin & sel;

    logic          o_wr_req, o_rd_req, o_busy, o_done, o_error, o_led;
    logic [LW-1:0] o_wr_len, o_rd_len;
    logic [AW-1:0] o_wr_addr, o_rd_addr;
    logic [DW-1:0] o_wr_data;
    logic [15:0]   o_err;
    assign o_wr_req  = sel ? b_wr_req  : a_wr_req;
    assign o_rd_req  = sel ? b_rd_req  : a_rd_req;
    assign o_busy    = sel ? b_busy    : a_busy;
    assign o_done    = sel ? b_done    : a_done;
    assign o_error   = sel ? b_error   : a_error;
    assign o_led     = sel ? b_led     : a_led;
    assign o_wr_len  = sel ? b_wr_len  : a_wr_len;
    assign o_rd_len  = sel ? b_rd_len  : a_rd_len;
    assign o_wr_addr = sel ? b_wr_addr : a_wr_addr;
    assign o_rd_addr = sel ? b_rd_addr : a_rd_addr;
    assign o_wr_data = sel ? b_wr_data : a_wr_data;
    assign o_err     = sel ? b_err     : a_err;

    sdram_burst_traffic_gen #(
        .APP_ADDR_WIDTH(AW), .APP_BURST_WIDTH(LW), .SDR_DQ_WIDTH(DW), .BURST_LEN(BL),
        .NUM_BURSTS(NB), .START_ADDR(32'd0), .PATTERN(0), .LOOP(0), .TIMEOUT(TO)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start),
        .wr_burst_req(a_wr_req), .wr_burst_len(a_wr_len), .wr_burst_addr(a_wr_addr),
        .wr_burst_data(a_wr_data), .wr_burst_data_req(a_dreq), .wr_burst_finish(a_wfin),
        .rd_burst_req(a_rd_req), .rd_burst_len(a_rd_len), .rd_burst_addr(a_rd_addr),
        .rd_burst_data(rd_data), .rd_burst_data_valid(a_rvalid), .rd_burst_finish(a_rfin),
        .busy(a_busy), .done(a_done), .error(a_error), .err_count(a_err),
        .o_led_receive_done(a_led)
    );

    sdram_burst_traffic_gen #(
        .APP_ADDR_WIDTH(AW), .APP_BURST_WIDTH(LW), .SDR_DQ_WIDTH(DW), .BURST_LEN(BL),
        .NUM_BURSTS(NB), .START_ADDR(TOP), .PATTERN(1), .LOOP(1), .TIMEOUT(TO)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start),
        .wr_burst_req(b_wr_req), .wr_burst_len(b_wr_len), .wr_burst_addr(b_wr_addr),
        .wr_burst_data(b_wr_data), .wr_burst_data_req(b_dreq), .wr_burst_finish(b_wfin),
        .rd_burst_req(b_rd_req), .rd_burst_len(b_rd_len), .rd_burst_addr(b_rd_addr),
        .rd_burst_data(rd_data), .rd_burst_data_valid(b_rvalid), .rd_burst_finish(b_rfin),
        .busy(b_busy), .done(b_done), .error(b_error), .err_count(b_err),
        .o_led_receive_done(b_led)
    );

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [AW-1:0] rd_addr_q[$];
    logic [DW-1:0] mem [logic [AW-1:0]];

    // Single comparison point for the whole bench.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bench model of one pass: burst addresses and write words in issue order.
    task automatic push_pass(input int seed, input int unsigned base, input int pattern);
        logic [AW-1:0] ad;
        logic [DW-1:0] w;
        int            k;
        for (int b = 0; b < NB; b++) begin
            ad = AW'(base + 32'(b * BL));
            wr_addr_q.push_back(ad);
            rd_addr_q.push_back(ad);
            for (int i = 0; i < BL; i++) begin
                k = b * BL + i;
                if (pattern == 0) w = DW'(seed + k);
                else              w = DW'(32'd1 << ((k + seed) % DW));
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic wait_req(input bit rd, output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            if ((rd ? o_rd_req : o_wr_req) == 1'b1) ok = 1'b1;
            else begin
                n++;
                @(negedge clk);
            end
        end
        if (!ok) check_eq(rd ? "rd_req_wait" : "wr_req_wait", 32'd0, 32'd1);
    endtask

    // Controller model for one pass: extra0 surplus data_req beats in write burst 0,
    // corrupt = global read beat index to flip bit 8 of (-1 none).
    task automatic serve(input int extra0, input int corrupt, input bit start_mid);
        logic [AW-1:0] a;
        bit            ok;
        for (int b = 0; b < NB; b++) begin
            wait_req(1'b0, ok);
            if (!ok) return;
            a = o_wr_addr;
            check_eq("wr_addr", 32'(a), 32'(wr_addr_q.pop_front()));
            for (int i = 0; i < BL + ((b == 0) ? extra0 : 0); i++) begin
                if (i < BL) begin
                    check_eq("wr_data", 32'(o_wr_data), 32'(exp_q.pop_front()));
                    mem[a + AW'(i)] = o_wr_data;
                end
                wr_dreq = 1'b1;
                @(negedge clk);
            end
            wr_dreq = 1'b0;
            wr_fin  = 1'b1;
            @(negedge clk);
            wr_fin  = 1'b0;
            check_eq("wr_req_drop", 32'(o_wr_req), 32'd0);
            if (start_mid && b == 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        for (int b = 0; b < NB; b++) begin
            wait_req(1'b1, ok);
            if (!ok) return;
            a = o_rd_addr;
            check_eq("rd_addr", 32'(a), 32'(rd_addr_q.pop_front()));
            for (int i = 0; i < BL; i++) begin
                rd_valid = 1'b1;
                rd_data  = mem[a + AW'(i)] ^ (((b * BL + i) == corrupt) ? 16'h0100 : 16'h0000);
                @(negedge clk);
            end
            rd_valid = 1'b0;
            rd_data  = 16'h0000;
            rd_fin   = 1'b1;
            @(negedge clk);
            rd_fin   = 1'b0;
            check_eq("rd_req_drop", 32'(o_rd_req), 32'd0);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("start_busy", 32'(o_busy), 32'd1);
        check_eq("start_done_clr", 32'(o_done), 32'd0);
        check_eq("start_err_clr", 32'(o_err), 32'd0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (o_done !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        check_eq("done", 32'(o_done), 32'd1);
        check_eq("busy_end", 32'(o_busy), 32'd0);
    endtask

    initial begin
        int  hi_cnt;
        bit  ok;
        sel = 1'b0; start = 1'b0; wr_dreq = 1'b0; wr_fin = 1'b0;
        rd_valid = 1'b0; rd_fin = 1'b0; rd_data = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        check_eq("rst_wr_req", 32'(o_wr_req), 32'd0);
        check_eq("rst_rd_req", 32'(o_rd_req), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_done", 32'(o_done), 32'd0);
        check_eq("rst_error", 32'(o_error), 32'd0);
        check_eq("rst_err_cnt", 32'(o_err), 32'd0);
        check_eq("rst_led", 32'(o_led), 32'd0);
        check_eq("rst_wr_len", 32'(o_wr_len), 32'd4);
        check_eq("rst_rd_len", 32'(o_rd_len), 32'd4);
        check_eq("rst_wr_addr", 32'(o_wr_addr), 32'd0);
        check_eq("rst_rd_addr", 32'(o_rd_addr), 32'd0);

        // clean pass
        push_pass(0, 32'd0, 0);
        pulse_start();
        serve(0, -1, 1'b0);
        wait_done();
        check_eq("p1_error", 32'(o_error), 32'd0);
        check_eq("p1_err_cnt", 32'(o_err), 32'd0);
        check_eq("p1_led", 32'(o_led), 32'd1);

        // read beat 5 corrupted
        push_pass(0, 32'd0, 0);
        pulse_start();
        serve(0, 5, 1'b0);
        wait_done();
        check_eq("p2_error", 32'(o_error), 32'd1);
        check_eq("p2_err_cnt", 32'(o_err), 32'd1);
        check_eq("p2_led", 32'(o_led), 32'd0);

        // five data_req beats in write burst 0
        push_pass(0, 32'd0, 0);
        pulse_start();
        serve(1, -1, 1'b0);
        wait_done();
        check_eq("p3_error", 32'(o_error), 32'd1);
        check_eq("p3_err_cnt", 32'(o_err), 32'd1);

        // controller never finishes
        pulse_start();
        wait_req(1'b0, ok);
        hi_cnt = 0;
        while (o_wr_req === 1'b1 && hi_cnt < 4 * TO) begin
            hi_cnt++;
            @(negedge clk);
        end
        check_eq("tmo_cycles", 32'(hi_cnt), 32'(TO));
        check_eq("tmo_req", 32'(o_wr_req), 32'd0);
        check_eq("tmo_done", 32'(o_done), 32'd1);
        check_eq("tmo_error", 32'(o_error), 32'd1);
        check_eq("tmo_err_cnt", 32'(o_err), 32'd1);
        check_eq("tmo_busy", 32'(o_busy), 32'd0);

        // stray valid during write, then reset during WR_WAIT
        pulse_start();
        wait_req(1'b0, ok);
        rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
        check_eq("stray_valid_err", 32'(o_err), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_req", 32'(o_wr_req), 32'd0);
        check_eq("rst_mid_busy", 32'(o_busy), 32'd0);
        check_eq("rst_mid_err", 32'(o_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // walking-one, loop mode, address wrap, start while busy
        sel = 1'b1;
        @(negedge clk);
        check_eq("b_rst_busy", 32'(o_busy), 32'd0);
        push_pass(0, TOP, 1);
        push_pass(1, TOP, 1);
        pulse_start();
        serve(0, -1, 1'b1);
        serve(0, -1, 1'b0);
        check_eq("b_error", 32'(o_error), 32'd0);
        check_eq("b_err_cnt", 32'(o_err), 32'd0);
        check_eq("b_done", 32'(o_done), 32'd0);
        check_eq("b_busy", 32'(o_busy), 32'd1);
        check_eq("b_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
